// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked ALU with iterative mul/divu and registered flags.
// Define ALU_MC_DIV_EN to build the iterative divu datapath.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] hi, lo, bq;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH-1:0] r1;
  logic           c1, v1, dz1;
  logic           fc, fdz;
  logic           long_op;
  logic [WIDTH:0] sum, diff, msum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef ALU_MC_DIV_EN
  logic             op_div, dz_q, ge;
  logic [WIDTH:0]   r2;
  logic [WIDTH-1:0] hi_d, lo_d;

  assign long_op = op[2] & op[1];
  assign r2      = {hi, lo[WIDTH-1]};
  assign ge      = r2 >= {1'b0, bq};
  assign hi_d    = ge ? (r2[WIDTH-1:0] - bq) : r2[WIDTH-1:0];
  assign lo_d    = {lo[WIDTH-2:0], ge};
`else
  assign long_op = (op == 3'b110);
`endif

  // Shift-add step: {carry, hi, lo} >> 1 after a conditional add of b.
  assign msum = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);

  always_comb begin
`ifdef ALU_MC_DIV_EN
    hi_n = op_div ? hi_d : msum[WIDTH:1];
    lo_n = op_div ? lo_d : {msum[0], lo[WIDTH-1:1]};
    fc   = ~op_div & (|msum[WIDTH:1]);
    fdz  = op_div & dz_q;
`else
    hi_n = msum[WIDTH:1];
    lo_n = {msum[0], lo[WIDTH-1:1]};
    fc   = |msum[WIDTH:1];
    fdz  = 1'b0;
`endif
  end

  always_comb begin
    r1  = '0;
    c1  = 1'b0;
    v1  = 1'b0;
    dz1 = 1'b0;
    unique case (op)
      3'b000: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = (a[WIDTH-1] == b[WIDTH-1]) &&
             (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        r1 = diff[WIDTH-1:0];
        c1 = ~diff[WIDTH];
        v1 = (a[WIDTH-1] != b[WIDTH-1]) &&
             (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r1 = a & b;
      3'b011: r1 = a | b;
      3'b100: r1 = a ^ b;
      3'b101: r1 = {{(WIDTH-1){1'b0}},
                    $signed(a) < $signed(b)};
      default: dz1 = op[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = long_op ? BUSY : DONE;
      BUSY: if (cnt == CW'(1)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      bq      <= '0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_dz <= 1'b0;
`ifdef ALU_MC_DIV_EN
      op_div  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          if (long_op) begin
            hi  <= '0;
            lo  <= a;
            bq  <= b;
            cnt <= CW'(WIDTH);
`ifdef ALU_MC_DIV_EN
            op_div <= op[0];
            dz_q   <= (b == '0);
`endif
          end else begin
            result  <= r1;
            flag_z  <= (r1 == '0);
            flag_n  <= r1[WIDTH-1];
            flag_c  <= c1;
            flag_v  <= v1;
            flag_dz <= dz1;
          end
        end
        BUSY: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result  <= lo_n;
            flag_z  <= (lo_n == '0);
            flag_n  <= lo_n[WIDTH-1];
            flag_c  <= fc;
            flag_v  <= 1'b0;
            flag_dz <= fdz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH = 32).
// Expected values come from a behavioural model using wide arithmetic.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        flag_z, flag_n, flag_c, flag_v, flag_dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o,
                                 input logic [31:0] x, y);
    exp_t e;
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r;
    logic c, v, dz;
    r = '0; c = 0; v = 0; dz = 0;
    e.lat = 1;
    case (o)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0]; c = s[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'b001: begin
        r = x - y; c = (x >= y);
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b110: begin
        p = {32'd0, x} * {32'd0, y};
        r = p[31:0]; c = |p[63:32];
        e.lat = 33;
      end
      default: begin
`ifdef ALU_MC_DIV_EN
        r = (y == 0) ? 32'hFFFF_FFFF : x / y;
        dz = (y == 0);
        e.lat = 33;
`else
        r = '0; dz = 1;
`endif
      end
    endcase
    e.r = r;
    e.f = {r == 0, r[31], c, v, dz};
    return e;
  endfunction

  task automatic run(input logic [2:0] o, input logic [31:0] x, y,
                     input int hold);
    exp_t e;
    int n;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; op = o; a = x; b = y;
    @(posedge clk);
    sbq.push_back(model(o, x, y));
    #1 in_valid = 0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    e = sbq.pop_front();
    chk("out_valid", out_valid, 1);
    chk("latency", n, e.lat);
    chk("result", result, e.r);
    chk("flags", {flag_z, flag_n, flag_c, flag_v, flag_dz}, e.f);
    if (hold > 0) begin
      out_ready = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_result", result, e.r);
        chk("hold_flags", {flag_z, flag_n, flag_c, flag_v, flag_dz}, e.f);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_out_valid", out_valid, 1);
        in_valid = ~in_valid;
        op = 3'b000;
        a = $urandom;
        b = $urandom;
      end
      in_valid = 0;
      out_ready = 1;
    end
    @(posedge clk);
    #1;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, flag_dz}, 0);
    @(negedge clk);
    rst_n = 1;

    run(3'b000, 32'h7FFF_FFFF, 32'd1, 0);
    run(3'b000, 32'hFFFF_FFFF, 32'd1, 0);
    run(3'b001, 32'd3, 32'd5, 0);
    run(3'b001, 32'd9, 32'd9, 0);
    run(3'b001, 32'h8000_0000, 32'd1, 0);
    run(3'b101, 32'hFFFF_FFFF, 32'd1, 0);
    run(3'b101, 32'd1, 32'hFFFF_FFFF, 0);
    run(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    run(3'b011, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run(3'b110, 32'h0001_0000, 32'h0001_0001, 0);
    run(3'b110, 32'd1234, 32'd5678, 0);
    run(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(3'b111, 32'd100, 32'd7, 0);
    run(3'b111, 32'd100, 32'd0, 0);
    run(3'b111, 32'hFFFF_FFFF, 32'd1, 0);
    run(3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 10);
    for (int i = 0; i < 24; i++)
      run(3'($urandom_range(0, 7)), $urandom, $urandom, i % 5 == 0 ? 2 : 0);

    // Abort a multiply partway through with an asynchronous reset.
    @(negedge clk);
    in_valid = 1; op = 3'b110; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    chk("abort_result", result, 0);
    chk("abort_flags", {flag_z, flag_n, flag_c, flag_v, flag_dz}, 0);
    rst_n = 1;
    repeat (40) begin
      @(posedge clk);
      #1 chk("abort_no_output", out_valid, 0);
    end
    run(3'b000, 32'd2, 32'd3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, handshaked successor to the single-cycle datapath ALU, parametrised in width. It adds XOR, signed set-less-than, an iterative unsigned multiply and an iterative unsigned divide. It also registers status flags. It sits in the execute stage of the multi-cycle core: it accepts one operation at a time over a valid/ready handshake and holds its registered result until the consumer takes it.

## Interface
- `WIDTH`, 32, operand/result width in bits; must be ≥ 4.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  block can accept a request
- `a`, `b`  in  WIDTH  operands
- `op`  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 mul, 111 divu
- `out_valid`  out  1  `result`/flags valid
- `out_ready`  in  1  consumer takes result
- `result`  out  WIDTH  registered result
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  zero, negative, carry, signed overflow
- `flag_dz`  out  1  divide by zero (divu only)

## Operation
- FSM states IDLE, BUSY, DONE.
- `in_ready` = (state == IDLE). A request is accepted when `in_valid && in_ready`; `a`, `b` and `op` are captured at that edge.
- Ops 000–101: result is computed at acceptance and the FSM goes IDLE→DONE.
- Ops 110/111: the FSM goes IDLE→BUSY and loads an iteration counter with WIDTH. It runs one shift-add (mul) or one restoring shift-subtract (divu) step per cycle. When the counter reaches 0 it goes BUSY→DONE.
- DONE: `out_valid` = 1, and outputs are stable until `out_valid && out_ready`; then DONE→IDLE.
- Arithmetic, all mod 2^WIDTH:
  - add/sub: `flag_c` = carry out (add) or NOT borrow, i.e. a ≥ b unsigned (sub); `flag_v` = signed overflow.
  - slt: result = 1 if $signed(a) < $signed(b), else 0.
  - mul: result = low WIDTH bits of the unsigned product; `flag_c` = 1 if the high WIDTH bits are non-zero.
  - divu: result = floor(a/b); the remainder is internal only.
  - If b = 0: result = all ones, `flag_dz` = 1. The FSM still spends WIDTH BUSY cycles.
- `flag_z` = (result == 0) and `flag_n` = result[WIDTH-1] for every op. `flag_c`/`flag_v` are 0 where not defined above. `flag_dz` is 0 for all ops except divu.
- `in_valid` while not in IDLE is ignored; no request is queued.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, all flags 0. The counter and internal registers are cleared.
- Reset mid-BUSY or mid-DONE aborts the operation; no result is produced.
- Latency from accept edge to `out_valid` high:
  - ops 000–101: 1 cycle
  - mul/divu: WIDTH+1 cycles
- Maximum throughput:
  - one single-cycle op per 2 cycles (accept, then DONE with `out_ready` = 1)
  - one mul/div per WIDTH+2 cycles
- Back-pressure: with `out_ready` = 0, DONE holds indefinitely and `result`/flags do not change.
- `in_ready` rises the cycle after the DONE handshake, never in the same cycle.

## Configuration
- `ALU_MC_DIV_EN` defined: the divu datapath (remainder register, subtractor) is compiled in and behaves as above.
- `ALU_MC_DIV_EN` undefined: op 111 takes the single-cycle path to DONE and returns result = 0, `flag_dz` = 1, `flag_z` = 1. The mul path is unaffected.

## Test plan
- Reset: assert `rst_n` = 0 mid-mul → next cycle `in_ready` = 1, `out_valid` = 0, `result` = 0, all flags 0.
- Add overflow: add a = 0x7FFFFFFF, b = 1 → after 1 cycle result = 0x80000000, n = 1, v = 1, c = 0, z = 0.
- Sub and slt: sub a = 3, b = 5 → result = 0xFFFFFFFE, c = 0, n = 1. Then slt a = 0xFFFFFFFF, b = 1 → result = 1.
- Multiply: mul a = 0x00010000, b = 0x00010001 → `out_valid` exactly 33 cycles after accept; result = 0x00010000, c = 1.
- Divide (`ALU_MC_DIV_EN` defined): divu a = 100, b = 7 → result = 14 after 33 cycles. Then divu b = 0 → result = 0xFFFFFFFF, dz = 1.
- Back-pressure: hold `out_ready` = 0 for 10 cycles after an xor of 0xF0F0F0F0 and 0xFFFF0000 → result stays 0x0F0FF0F0 and `in_ready` stays 0. Pulsing `in_valid` during the hold is ignored.
